ucsbece154b_dual_issue_ctrl: RTL and testbench
==============================================

UCSBECE154B_DUAL_ISSUE_CTRL -- requirements
Module: ucsbece154b_dual_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; legal values are powers of two, minimum 4.
REQ-002 SHALL have ports: clk input 1, rising-edge clock.
REQ-003 SHALL have port reset input 1, synchronous active-high reset.
REQ-004 SHALL have ports fetch_valid_i input 2, slot valids where bit0 is the older slot; fetch_instr1_i, fetch_instr2_i, fetch_pc1_i, fetch_pc2_i input 32 each.
REQ-005 SHALL have port fetch_ready_o output 1, high when the queue can accept 2 entries this cycle.
REQ-006 SHALL have ports flush_i input 1, mispredict flush; stall_i input 1, decode stall.
REQ-007 SHALL have port issue_valid_o output 2, where bit0 is the older slot; issue_instr1_o, issue_instr2_o, issue_pc1_o, issue_pc2_o output 32 each.
REQ-008 SHALL have port count_o output log2(DEPTH)+1, queue occupancy.
REQ-009 SHALL have port split_o output 1, high when 2 or more entries are queued but only the head is issued.
REQ-010 SHALL have ports dual_cnt_o and split_cnt_o, output 32 each, statistics counters.

Function
REQ-011 SHALL be a DEPTH-entry circular FIFO of {instr,pc} with head and tail pointers modulo DEPTH and a registered count.
REQ-012 SHALL drive fetch_ready_o = (DEPTH - count) >= 2, computed from the registered count only.
REQ-013 SHALL push on fetch_ready_o && fetch_valid_i[0]: push slot1, then slot2 if fetch_valid_i[1]; 2'b10 pushes nothing.
REQ-014 SHALL make a pushed entry visible on issue outputs no earlier than the next cycle; there is no bypass.
REQ-015 SHALL drive issue_valid_o[0] = (count >= 1) && !flush_i, with head on slot1.
REQ-016 SHALL drive issue_valid_o[1] = issue_valid_o[0] && (count >= 2) && pairable(head, head+1).
REQ-017 SHALL treat a pair as not pairable if any of the following hold: head writes rd != x0 and the second instruction reads rd (RAW); both write the same rd != x0 (WAW); both are memory ops (opcode 0000011 or 0100011); both are control ops (opcode 1100011, 1101111 or 1100111).
REQ-018 SHALL use these rules: writes rd = all opcodes except 1100011 and 0100011; reads rs1 = all opcodes except 0110111, 0010111 and 1101111; reads rs2 = opcodes 0110011, 0100011 and 1100011.
REQ-019 SHALL pop popcount(issue_valid_o) entries when !stall_i, and pop 0 entries when stall_i.
REQ-020 SHALL allow simultaneous push and pop, with count_next = count + pushed - popped; a push alone SHALL never exceed DEPTH.
REQ-021 SHALL treat a head or tail pointer wrap past DEPTH-1 to 0 as transparent to ordering.
REQ-022 SHALL on flush_i clear the queue next cycle (count = 0, head = tail); any same-cycle push is dropped and the pop is suppressed.
REQ-023 SHALL assert split_o = issue_valid_o[0] && !issue_valid_o[1] && count >= 2 && !stall_i.
REQ-024 SHALL leave the queue unchanged when stall_i and flush_i are both low and there is no push.

Reset
REQ-025 SHALL on reset set count = 0 and head = tail = 0; issue_valid_o = 0, fetch_ready_o = 1, split_o = 0, dual_cnt_o = split_cnt_o = 0 in the following cycle.
REQ-026 SHALL have reset override flush, push and pop; entry storage needs no reset, and issue_instr and issue_pc outputs are don't-care while invalid.

Configuration
REQ-027 SHALL, with macro ISSUE_STATS_EN defined, increment dual_cnt_o on cycles with issue_valid_o = 2'b11 && !stall_i, and increment split_cnt_o on split_o; both counters wrap at 2^32.
REQ-028 SHALL, without ISSUE_STATS_EN, tie dual_cnt_o and split_cnt_o to 0 and implement no counter flops.

Verification
REQ-029 SHALL cover independent pair: push addi x5,x0,1 / addi x6,x0,2 at cycle 0 -> cycle 1 issue_valid_o = 2'b11, count_o = 2 then 0.
REQ-030 SHALL cover RAW split: push addi x5,x0,1 / add x7,x5,x5 -> cycle 1 issue_valid_o = 2'b01 and split_o = 1; cycle 2 issue_valid_o = 2'b01 with add on slot1.
REQ-031 SHALL cover memory and control pairing: push lw x1,0(x2) / sw x3,4(x4) -> 2'b01; push beq x1,x2,8 / addi x9,x9,1 -> 2'b11.
REQ-032 SHALL cover full and wrap: with stall_i = 1, push 2 pairs -> count_o = 4 and fetch_ready_o = 0, further pushes ignored; release stall -> entries issue in push order after the pointers wrap.
REQ-033 SHALL cover flush: with count_o = 3 and a push in the same cycle as flush_i -> issue_valid_o = 0 that cycle, count_o = 0 next cycle, and the pushed entries are never issued.
REQ-034 SHALL cover stats: with ISSUE_STATS_EN, 3 dual-issue cycles plus 2 split cycles -> dual_cnt_o = 3 and split_cnt_o = 2; without the macro -> both 0.

Source files
------------

// File: rtl/ucsbece154b_dual_issue_ctrl_if.sv
// Fetch/issue bundle for the dual-issue queue controller.
// The slave modport is the controller's view; the master modport drives fetch and sinks issue.
interface ucsbece154b_dual_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    fetch_valid_i;
  logic [31:0]   fetch_instr1_i;
  logic [31:0]   fetch_instr2_i;
  logic [31:0]   fetch_pc1_i;
  logic [31:0]   fetch_pc2_i;
  logic          fetch_ready_o;
  logic          flush_i;
  logic          stall_i;
  logic [1:0]    issue_valid_o;
  logic [31:0]   issue_instr1_o;
  logic [31:0]   issue_instr2_o;
  logic [31:0]   issue_pc1_o;
  logic [31:0]   issue_pc2_o;
  logic [CW-1:0] count_o;
  logic          split_o;
  logic [31:0]   dual_cnt_o;
  logic [31:0]   split_cnt_o;

  modport slave (
    input  fetch_valid_i, fetch_instr1_i, fetch_instr2_i, fetch_pc1_i, fetch_pc2_i,
    input  flush_i, stall_i,
    output fetch_ready_o, issue_valid_o, issue_instr1_o, issue_instr2_o,
    output issue_pc1_o, issue_pc2_o, count_o, split_o, dual_cnt_o, split_cnt_o
  );

  modport master (
    output fetch_valid_i, fetch_instr1_i, fetch_instr2_i, fetch_pc1_i, fetch_pc2_i,
    output flush_i, stall_i,
    input  fetch_ready_o, issue_valid_o, issue_instr1_o, issue_instr2_o,
    input  issue_pc1_o, issue_pc2_o, count_o, split_o, dual_cnt_o, split_cnt_o
  );
endinterface

// File: rtl/ucsbece154b_dual_issue_ctrl.sv
// Dual-issue instruction queue: circular FIFO with head-pair hazard check.
// Define ISSUE_STATS_EN to build the dual/split issue statistics counters.
module ucsbece154b_dual_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  ucsbece154b_dual_issue_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic f_writes_rd(input logic [6:0] op);
    return (op != OP_BRANCH) && (op != OP_STORE);
  endfunction

  function automatic logic f_reads_rs1(input logic [6:0] op);
    return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  function automatic logic f_reads_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic f_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic f_is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  logic [31:0]   r_instr_q [DEPTH];
  logic [31:0]   r_pc_q    [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_head_p1;
  logic [PW-1:0] w_tail_p1;
  logic [31:0]   w_i1;
  logic [31:0]   w_i2;
  logic          w_raw;
  logic          w_waw;
  logic          w_pairable;
  logic          w_ready;
  logic          w_push;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_n;
  logic [1:0]    w_issue_valid;
  logic          w_split;

  assign w_head_p1 = r_head + PW'(1);
  assign w_tail_p1 = r_tail + PW'(1);
  assign w_i1      = r_instr_q[r_head];
  assign w_i2      = r_instr_q[w_head_p1];

  // Second slot only checks against the head; x0 never creates a dependency.
  assign w_raw = f_writes_rd(w_i1[6:0]) && (w_i1[11:7] != 5'd0) &&
                 ((f_reads_rs1(w_i2[6:0]) && (w_i2[19:15] == w_i1[11:7])) ||
                  (f_reads_rs2(w_i2[6:0]) && (w_i2[24:20] == w_i1[11:7])));
  assign w_waw = f_writes_rd(w_i1[6:0]) && f_writes_rd(w_i2[6:0]) &&
                 (w_i1[11:7] != 5'd0) && (w_i1[11:7] == w_i2[11:7]);
  assign w_pairable = !w_raw && !w_waw &&
                      !(f_is_mem(w_i1[6:0]) && f_is_mem(w_i2[6:0])) &&
                      !(f_is_ctrl(w_i1[6:0]) && f_is_ctrl(w_i2[6:0]));

  assign w_ready          = (r_count <= CW'(DEPTH - 2));
  assign w_issue_valid[0] = (r_count >= CW'(1)) && !bus.flush_i;
  assign w_issue_valid[1] = w_issue_valid[0] && (r_count >= CW'(2)) && w_pairable;
  assign w_split          = w_issue_valid[0] && !w_issue_valid[1] &&
                            (r_count >= CW'(2)) && !bus.stall_i;

  assign w_push   = w_ready && bus.fetch_valid_i[0] && !bus.flush_i;
  assign w_push_n = !w_push ? CW'(0) : (bus.fetch_valid_i[1] ? CW'(2) : CW'(1));
  assign w_pop_n  = bus.stall_i ? CW'(0) :
                    (CW'(w_issue_valid[0]) + CW'(w_issue_valid[1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + PW'(w_push_n);
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_instr_q[r_tail] <= bus.fetch_instr1_i;
      r_pc_q[r_tail]    <= bus.fetch_pc1_i;
      if (bus.fetch_valid_i[1]) begin
        r_instr_q[w_tail_p1] <= bus.fetch_instr2_i;
        r_pc_q[w_tail_p1]    <= bus.fetch_pc2_i;
      end
    end
  end

  assign bus.fetch_ready_o  = w_ready;
  assign bus.issue_valid_o  = w_issue_valid;
  assign bus.issue_instr1_o = w_i1;
  assign bus.issue_instr2_o = w_i2;
  assign bus.issue_pc1_o    = r_pc_q[r_head];
  assign bus.issue_pc2_o    = r_pc_q[w_head_p1];
  assign bus.count_o        = r_count;
  assign bus.split_o        = w_split;

`ifdef ISSUE_STATS_EN
  logic [31:0] r_dual_cnt;
  logic [31:0] r_split_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dual_cnt  <= '0;
      r_split_cnt <= '0;
    end else begin
      if ((w_issue_valid == 2'b11) && !bus.stall_i) r_dual_cnt <= r_dual_cnt + 32'd1;
      if (w_split) r_split_cnt <= r_split_cnt + 32'd1;
    end
  end

  assign bus.dual_cnt_o  = r_dual_cnt;
  assign bus.split_cnt_o = r_split_cnt;
`else
  assign bus.dual_cnt_o  = '0;
  assign bus.split_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ucsbece154b_dual_issue_ctrl.sv
// Directed bench for the dual-issue queue: pairing, hazards, full/wrap, flush, stats.
module tb_ucsbece154b_dual_issue_ctrl;
  localparam logic [31:0] ADDI5  = 32'h00100293;
  localparam logic [31:0] ADDI6  = 32'h00200313;
  localparam logic [31:0] ADD7   = 32'h005283B3;
  localparam logic [31:0] LW1    = 32'h00012083;
  localparam logic [31:0] SW3    = 32'h00322223;
  localparam logic [31:0] BEQ    = 32'h00208463;
  localparam logic [31:0] ADDI9  = 32'h00148493;
  localparam logic [31:0] ADDI10 = 32'h00A00513;
  localparam logic [31:0] ADDI11 = 32'h00B00593;
  localparam logic [31:0] ADDI12 = 32'h00C00613;
  localparam logic [31:0] ADDI13 = 32'h00D00693;
  localparam logic [31:0] ADDI14 = 32'h00E00713;
  localparam logic [31:0] ADDI15 = 32'h00F00793;
`ifdef ISSUE_STATS_EN
  localparam logic [31:0] EXP_DUAL  = 32'd4;
  localparam logic [31:0] EXP_SPLIT = 32'd3;
`else
  localparam logic [31:0] EXP_DUAL  = 32'd0;
  localparam logic [31:0] EXP_SPLIT = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ucsbece154b_dual_issue_ctrl_if #(.DEPTH(4)) bus ();
  ucsbece154b_dual_issue_ctrl #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] p1, input logic [31:0] p2);
    bus.fetch_valid_i  = v;
    bus.fetch_instr1_i = i1;
    bus.fetch_instr2_i = i2;
    bus.fetch_pc1_i    = p1;
    bus.fetch_pc2_i    = p2;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    drive(2'b00, '0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("rst_ready", 32'(bus.fetch_ready_o), 32'd1);
    chk("rst_split", 32'(bus.split_o), 32'd0);
    chk("rst_dual_cnt", bus.dual_cnt_o, 32'd0);
    chk("rst_split_cnt", bus.split_cnt_o, 32'd0);

    // independent pair
    drive(2'b11, ADDI5, ADDI6, 32'h100, 32'h104);
    #1;
    chk("pair_nobypass", 32'(bus.issue_valid_o), 32'd0);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("pair_count", 32'(bus.count_o), 32'd2);
    chk("pair_valid", 32'(bus.issue_valid_o), 32'd3);
    chk("pair_i1", bus.issue_instr1_o, ADDI5);
    chk("pair_i2", bus.issue_instr2_o, ADDI6);
    chk("pair_pc2", bus.issue_pc2_o, 32'h104);
    chk("pair_split", 32'(bus.split_o), 32'd0);
    tick();
    chk("pair_drained", 32'(bus.count_o), 32'd0);

    // RAW split
    drive(2'b11, ADDI5, ADD7, 32'h200, 32'h204);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("raw_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("raw_split", 32'(bus.split_o), 32'd1);
    tick();
    chk("raw_valid2", 32'(bus.issue_valid_o), 32'd1);
    chk("raw_i1", bus.issue_instr1_o, ADD7);
    chk("raw_pc1", bus.issue_pc1_o, 32'h204);
    chk("raw_split2", 32'(bus.split_o), 32'd0);
    tick();

    // memory pair, then branch + alu
    drive(2'b11, LW1, SW3, 32'h300, 32'h304);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("mem_valid", 32'(bus.issue_valid_o), 32'd1);
    tick();
    chk("mem_i1", bus.issue_instr1_o, SW3);
    tick();
    drive(2'b11, BEQ, ADDI9, 32'h400, 32'h404);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("ctrl_valid", 32'(bus.issue_valid_o), 32'd3);
    tick();
    chk("ctrl_drained", 32'(bus.count_o), 32'd0);

    // shift pointers by one, then fill under stall so the queue wraps
    drive(2'b01, ADDI10, ADDI15, 32'h500, 32'h504);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("single_i1", bus.issue_instr1_o, ADDI10);
    chk("single_valid", 32'(bus.issue_valid_o), 32'd1);
    tick();
    bus.stall_i = 1'b1;
    drive(2'b11, ADDI11, ADDI12, 32'h600, 32'h604);
    tick();
    drive(2'b11, ADDI13, ADDI14, 32'h608, 32'h60C);
    #1;
    chk("fill_count2", 32'(bus.count_o), 32'd2);
    chk("fill_ready2", 32'(bus.fetch_ready_o), 32'd1);
    chk("stall_split", 32'(bus.split_o), 32'd0);
    tick();
    drive(2'b11, ADDI15, ADDI15, 32'h700, 32'h704);
    #1;
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_ready", 32'(bus.fetch_ready_o), 32'd0);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("full_hold", 32'(bus.count_o), 32'd4);
    bus.stall_i = 1'b0;
    #1;
    chk("wrap_valid1", 32'(bus.issue_valid_o), 32'd3);
    chk("wrap_a1", bus.issue_instr1_o, ADDI11);
    chk("wrap_a2", bus.issue_instr2_o, ADDI12);
    tick();
    chk("wrap_b1", bus.issue_instr1_o, ADDI13);
    chk("wrap_b2", bus.issue_instr2_o, ADDI14);
    chk("wrap_pc2", bus.issue_pc2_o, 32'h60C);
    chk("wrap_count", 32'(bus.count_o), 32'd2);
    tick();
    chk("wrap_drained", 32'(bus.count_o), 32'd0);

    // flush with three queued entries
    bus.stall_i = 1'b1;
    drive(2'b11, ADDI5, ADD7, 32'h800, 32'h804);
    tick();
    drive(2'b01, ADDI10, ADDI15, 32'h808, 32'h80C);
    tick();
    chk("flush_pre_count", 32'(bus.count_o), 32'd3);
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b0;
    drive(2'b11, ADDI15, ADDI15, 32'h900, 32'h904);
    #1;
    chk("flush_valid", 32'(bus.issue_valid_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("flush_count", 32'(bus.count_o), 32'd0);
    chk("flush_ready", 32'(bus.fetch_ready_o), 32'd1);
    drive(2'b01, ADDI11, ADDI15, 32'hA00, 32'hA04);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("post_flush_i1", bus.issue_instr1_o, ADDI11);
    chk("post_flush_count", 32'(bus.count_o), 32'd1);
    bus.flush_i = 1'b1;
    drive(2'b11, ADDI15, ADDI15, 32'hB00, 32'hB04);
    tick();
    bus.flush_i = 1'b0;
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("flush_drop_count", 32'(bus.count_o), 32'd0);
    tick();
    chk("flush_drop_valid", 32'(bus.issue_valid_o), 32'd0);

    // WAW split
    drive(2'b11, ADDI5, ADDI5, 32'hC00, 32'hC04);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    #1;
    chk("waw_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("waw_split", 32'(bus.split_o), 32'd1);
    tick();
    tick();
    chk("waw_drained", 32'(bus.count_o), 32'd0);

    chk("stats_dual", bus.dual_cnt_o, EXP_DUAL);
    chk("stats_split", bus.split_cnt_o, EXP_SPLIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
